atm_controller_param: RTL
=========================

Name: atm_controller_param

Overview:
Parametrised next-generation ATM transaction controller, the DUT driven by the team's ATM tester benches. Handles card detection, N-digit PIN capture and compare, an attempt counter with warning and lockout, and deposit/withdrawal against a BAL_W-bit balance register with an insufficient-funds check. PIN length, attempt limits and data widths are parameters; edge-detected strobes and deposit saturation are new behaviour.

Parameters:
PIN_DIGITS, 4, number of 4-bit PIN digits (1..8)
MAX_INTENTOS, 3, wrong-PIN count that causes lockout (>=1)
ADVERT_INTENTOS, 2, wrong-PIN count that raises ADVERTENCIA (< MAX_INTENTOS)
BAL_W, 64, balance width
MONTO_W, 32, amount width (<= BAL_W)
TIMEOUT_CICLOS, 64, inactivity limit in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  asynchronous, active-low reset
TARJETA_RECIBIDA  in  1  card-present level
DIGITO_STB  in  1  digit strobe, level, may be held many cycles
DIGITO  in  4  BCD digit, valid while DIGITO_STB is high
PIN_CORRECTO  in  4*PIN_DIGITS  stored PIN, first digit in MS nibble
TIPO_TRANS  in  1  0 = deposit, 1 = withdrawal, sampled with MONTO_STB
MONTO_STB  in  1  amount strobe, level
MONTO  in  MONTO_W  transaction amount
BALANCE_INICIAL  in  BAL_W  opening balance
BALANCE  out  BAL_W  current balance
BALANCE_ACTUALIZADO  out  1  one-cycle pulse, balance changed or transaction done
ENTREGAR_DINERO  out  1  one-cycle pulse, successful withdrawal
FONDOS_INSUFICIENTES  out  1  one-cycle pulse, withdrawal rejected
PIN_INCORRECTO  out  1  one-cycle pulse per wrong PIN
ADVERTENCIA  out  1  level, wrong count >= ADVERT_INTENTOS
BLOQUEO  out  1  level, lockout active

Behaviour:
- Reset (RESET=0, async): all outputs 0, state IDLE, attempt and digit counters 0, init flag cleared. On the first rising edge after release, BALANCE <= BALANCE_INICIAL and the init flag is set. No other action occurs on that edge.
- Strobes are rising-edge detected against a registered copy of the previous cycle's value. A held strobe counts once. An edge is acted on at the same clock edge it is detected, so the pulse outputs are high for exactly the following cycle.
- IDLE: TARJETA_RECIBIDA 0->1 -> PIN. All other strobes are ignored.
- PIN: each DIGITO_STB edge shifts DIGITO into pin_reg LS nibble and increments the digit count.
  - When the count reaches PIN_DIGITS (on that edge), compare with PIN_CORRECTO and clear the count.
  - Match: attempts <= 0, ADVERTENCIA <= 0, go to ESPERA_MONTO.
  - Mismatch: attempts += 1 and PIN_INCORRECTO pulses.
  - New attempts >= ADVERT_INTENTOS -> ADVERTENCIA=1.
  - New attempts == MAX_INTENTOS -> BLOQUEO state. Otherwise stay in PIN for re-entry.
- ESPERA_MONTO: on a MONTO_STB edge, sample TIPO_TRANS and MONTO (zero-extended to BAL_W). Result is registered, then go to IDLE.
  - Deposit: BALANCE <= BALANCE + MONTO, saturating at 2^BAL_W-1. BALANCE_ACTUALIZADO pulses.
  - Withdrawal with MONTO <= BALANCE: BALANCE -= MONTO. BALANCE_ACTUALIZADO and ENTREGAR_DINERO pulse.
  - Withdrawal with MONTO > BALANCE: BALANCE unchanged, FONDOS_INSUFICIENTES pulses.
  - MONTO = 0 is a valid transaction: pulses fire, balance unchanged.
- BLOQUEO: BLOQUEO=1 and ADVERTENCIA=1. All inputs are ignored. Only RESET exits.
- Boundaries:
  - Card edges outside IDLE are ignored.
  - DIGITO_STB outside PIN and MONTO_STB outside ESPERA_MONTO are ignored.
  - Simultaneous edges: only the strobe relevant to the current state is acted on.
  - The attempt counter persists across card sessions until a correct PIN or RESET.
  - Reset mid-transaction aborts with no balance change, and the balance reloads from BALANCE_INICIAL.

Optional Feature:
INACTIVITY_TIMEOUT_EN
- Defined: adds output port TIMEOUT (1 bit). In PIN and ESPERA_MONTO, a cycle counter clears on every accepted strobe edge and on state entry. When it reaches TIMEOUT_CICLOS, the block drops the session: TIMEOUT pulses one cycle, the partial PIN and digit count are cleared, state goes to IDLE, and attempts and balance are unchanged.
- Undefined: no TIMEOUT port and no counter, and sessions wait indefinitely.

Test Plan:
- Reset, BALANCE_INICIAL=0, PIN_CORRECTO=16'h3566. Card, digits 3,5,6,6 (STB held 3 cycles each), deposit MONTO=10000 -> BALANCE=10000, BALANCE_ACTUALIZADO one cycle, attempts 0.
- Continue: card, PIN 3566, TIPO_TRANS=1, MONTO=7000 -> BALANCE=3000, ENTREGAR_DINERO and BALANCE_ACTUALIZADO one cycle each.
- Card, PINs 3561, 1111, 1534 -> PIN_INCORRECTO pulses 3 times, ADVERTENCIA=1 after the 2nd, BLOQUEO=1 after the 3rd. A later correct PIN and MONTO_STB have no effect.
- RESET low 2 cycles then high -> BLOQUEO=0, ADVERTENCIA=0, BALANCE=BALANCE_INICIAL. One-cycle card pulse, PIN 3566, deposit 10000 -> BALANCE=10000.
- Withdraw 900000 with BALANCE=10000 -> FONDOS_INSUFICIENTES one cycle, BALANCE stays 10000, no ENTREGAR_DINERO. Also: BALANCE_INICIAL=2^64-5, deposit 10 -> BALANCE=2^64-1.
- With INACTIVITY_TIMEOUT_EN and TIMEOUT_CICLOS=16: card, two digits, then idle 16 cycles -> TIMEOUT pulses, state IDLE. A new card plus PIN 3566 is accepted on the first try.

Source files
------------

// File: rtl/atm_controller_param.sv
// Parametrised ATM transaction controller: card detect, N-digit PIN check with lockout,
// deposit/withdrawal on a BAL_W-bit balance. Optional macro INACTIVITY_TIMEOUT_EN adds TIMEOUT.
module atm_controller_param #(
  parameter int PIN_DIGITS      = 4,
  parameter int MAX_INTENTOS    = 3,
  parameter int ADVERT_INTENTOS = 2,
  parameter int BAL_W           = 64,
  parameter int MONTO_W         = 32,
  parameter int TIMEOUT_CICLOS  = 64
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TARJETA_RECIBIDA,
  input  logic                    DIGITO_STB,
  input  logic [3:0]              DIGITO,
  input  logic [4*PIN_DIGITS-1:0] PIN_CORRECTO,
  input  logic                    TIPO_TRANS,
  input  logic                    MONTO_STB,
  input  logic [MONTO_W-1:0]      MONTO,
  input  logic [BAL_W-1:0]        BALANCE_INICIAL,
  output logic [BAL_W-1:0]        BALANCE,
  output logic                    BALANCE_ACTUALIZADO,
  output logic                    ENTREGAR_DINERO,
  output logic                    FONDOS_INSUFICIENTES,
  output logic                    PIN_INCORRECTO,
  output logic                    ADVERTENCIA,
  output logic                    BLOQUEO
`ifdef INACTIVITY_TIMEOUT_EN
  ,
  output logic                    TIMEOUT
`endif
);

  localparam int PW = 4 * PIN_DIGITS;
  localparam int DW = $clog2(PIN_DIGITS + 1);
  localparam int AW = $clog2(MAX_INTENTOS + 1);

  if (PIN_DIGITS < 1 || PIN_DIGITS > 8 || MAX_INTENTOS < 1 ||
      ADVERT_INTENTOS >= MAX_INTENTOS || MONTO_W > BAL_W || TIMEOUT_CICLOS < 1) begin : g_bad_param
    $error("atm_controller_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_PIN, S_ESPERA_MONTO, S_BLOQUEO} state_t;

  state_t          r_state;
  logic            r_init;
  logic            r_card_q, r_dig_q, r_monto_q;
  logic [PW-1:0]   r_pin;
  logic [DW-1:0]   r_dig;
  logic [AW-1:0]   r_att;

  logic            w_card_edge, w_dig_edge, w_monto_edge;
  logic [PW-1:0]   w_pin_next;
  logic [DW-1:0]   w_dig_next;
  logic [AW-1:0]   w_att_next;
  logic [BAL_W-1:0] w_monto;
  logic [BAL_W:0]  w_sum;
  logic [BAL_W-1:0] w_dep;
  logic            w_fondos_ok;

  assign w_card_edge  = TARJETA_RECIBIDA & ~r_card_q;
  assign w_dig_edge   = DIGITO_STB & ~r_dig_q;
  assign w_monto_edge = MONTO_STB & ~r_monto_q;
  assign w_pin_next   = (r_pin << 4) | PW'(DIGITO);
  assign w_dig_next   = r_dig + DW'(1);
  assign w_att_next   = r_att + AW'(1);
  assign w_monto      = BAL_W'(MONTO);
  assign w_sum        = {1'b0, BALANCE} + {1'b0, w_monto};
  // Carry out of the add means the deposit overflowed: clamp to all ones.
  assign w_dep        = w_sum[BAL_W] ? '1 : w_sum[BAL_W-1:0];
  assign w_fondos_ok  = (w_monto <= BALANCE);

`ifdef INACTIVITY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] r_tcnt;
  logic          w_active, w_accept, w_to_hit;

  assign w_active = r_init && (r_state == S_PIN || r_state == S_ESPERA_MONTO);
  assign w_accept = (r_state == S_PIN && w_dig_edge) ||
                    (r_state == S_ESPERA_MONTO && w_monto_edge);
  assign w_to_hit = w_active && !w_accept && (r_tcnt == TW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                    r_tcnt <= '0;
    else if (!w_active || w_accept || w_to_hit) r_tcnt <= '0;
    else                           r_tcnt <= r_tcnt + TW'(1);
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state              <= S_IDLE;
      r_init               <= 1'b0;
      r_card_q             <= 1'b0;
      r_dig_q              <= 1'b0;
      r_monto_q            <= 1'b0;
      r_pin                <= '0;
      r_dig                <= '0;
      r_att                <= '0;
      BALANCE              <= '0;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
`ifdef INACTIVITY_TIMEOUT_EN
      TIMEOUT              <= 1'b0;
`endif
    end else begin
      r_card_q             <= TARJETA_RECIBIDA;
      r_dig_q              <= DIGITO_STB;
      r_monto_q            <= MONTO_STB;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
`ifdef INACTIVITY_TIMEOUT_EN
      TIMEOUT              <= 1'b0;
`endif
      if (!r_init) begin
        // First edge after reset only loads the opening balance.
        r_init  <= 1'b1;
        BALANCE <= BALANCE_INICIAL;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_card_edge) begin
              r_state <= S_PIN;
              r_dig   <= '0;
            end
          end
          S_PIN: begin
            if (w_dig_edge) begin
              r_pin <= w_pin_next;
              if (w_dig_next == DW'(PIN_DIGITS)) begin
                r_dig <= '0;
                if (w_pin_next == PIN_CORRECTO) begin
                  r_att       <= '0;
                  ADVERTENCIA <= 1'b0;
                  r_state     <= S_ESPERA_MONTO;
                end else begin
                  r_att          <= w_att_next;
                  PIN_INCORRECTO <= 1'b1;
                  if (w_att_next >= AW'(ADVERT_INTENTOS)) ADVERTENCIA <= 1'b1;
                  if (w_att_next == AW'(MAX_INTENTOS)) begin
                    r_state     <= S_BLOQUEO;
                    BLOQUEO     <= 1'b1;
                    ADVERTENCIA <= 1'b1;
                  end
                end
              end else begin
                r_dig <= w_dig_next;
              end
            end
          end
          S_ESPERA_MONTO: begin
            if (w_monto_edge) begin
              r_state <= S_IDLE;
              if (!TIPO_TRANS) begin
                BALANCE             <= w_dep;
                BALANCE_ACTUALIZADO <= 1'b1;
              end else if (w_fondos_ok) begin
                BALANCE             <= BALANCE - w_monto;
                BALANCE_ACTUALIZADO <= 1'b1;
                ENTREGAR_DINERO     <= 1'b1;
              end else begin
                FONDOS_INSUFICIENTES <= 1'b1;
              end
            end
          end
          S_BLOQUEO: begin
            BLOQUEO     <= 1'b1;
            ADVERTENCIA <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
`ifdef INACTIVITY_TIMEOUT_EN
        if (w_to_hit) begin
          r_state <= S_IDLE;
          r_pin   <= '0;
          r_dig   <= '0;
          TIMEOUT <= 1'b1;
        end
`endif
      end
    end
  end

endmodule
